// File: rtl/sbh_pkg.sv
// Shared types and defaults for the sign bit hiding recovery path.
package sbh_pkg;

    localparam int unsigned COEFF_W_DEF       = 16;
    localparam int unsigned LEVEL_W           = COEFF_W_DEF - 1;
    localparam int unsigned CG_SIZE_DEF       = 16;
    localparam int unsigned POS_W_DEF         = 4;
    localparam int unsigned SBH_THRESHOLD_DEF = 4;

    typedef enum logic [1:0] {
        StLoad,
        StScan,
        StDecide,
        StEmit
    } sbh_state_e;

    // One stored coefficient: unsigned magnitude plus parsed sign (1 = negative).
    typedef struct packed {
        logic [LEVEL_W-1:0] level;
        logic               sign;
    } sbh_entry_t;

endpackage

// File: rtl/sbh_nz_parity_scan.sv
// Serial scanner over one coefficient group: finds the first and last non-zero
// scan positions and the parity of the sum of levels, one entry per cycle.
module sbh_nz_parity_scan #(
    parameter int unsigned LEVEL_W = 15,
    parameter int unsigned CG_SIZE = 16,
    parameter int unsigned POS_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEVEL_W-1:0] level,
    output logic [POS_W-1:0]   idx,
    output logic               done,
    output logic [POS_W-1:0]   first_nz,
    output logic [POS_W-1:0]   last_nz,
    output logic               has_nz,
    output logic               parity
);

    localparam logic [POS_W-1:0] LastIdx = POS_W'(CG_SIZE - 1);

    logic [POS_W-1:0] idx_q;
    logic             busy_q;
    logic [POS_W-1:0] first_nz_q;
    logic [POS_W-1:0] last_nz_q;
    logic             has_nz_q;
    logic             parity_q;

    assign idx      = idx_q;
    // Asserted during the cycle that consumes the final entry.
    assign done     = busy_q && (idx_q == LastIdx);
    assign first_nz = first_nz_q;
    assign last_nz  = last_nz_q;
    assign has_nz   = has_nz_q;
    assign parity   = parity_q;

    // Walk the entries in scan order; results stay valid until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            busy_q     <= 1'b0;
            first_nz_q <= '0;
            last_nz_q  <= '0;
            has_nz_q   <= 1'b0;
            parity_q   <= 1'b0;
        end else if (start) begin
            idx_q      <= '0;
            busy_q     <= 1'b1;
            first_nz_q <= '0;
            last_nz_q  <= '0;
            has_nz_q   <= 1'b0;
            parity_q   <= 1'b0;
        end else if (busy_q) begin
            if (level != '0) begin
                if (!has_nz_q) begin
                    first_nz_q <= idx_q;
                end
                last_nz_q <= idx_q;
                has_nz_q  <= 1'b1;
            end
            // Only the LSB of the running sum matters.
            parity_q <= parity_q ^ level[0];
            if (idx_q == LastIdx) begin
                busy_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sbh_sign_recovery.sv
// Decoder-side sign bit hiding recovery: stores one coefficient group, scans it,
// infers the hidden sign from level parity and streams signed coefficients out.
module sbh_sign_recovery
    import sbh_pkg::*;
#(
    parameter int unsigned COEFF_W       = COEFF_W_DEF,
    parameter int unsigned CG_SIZE       = CG_SIZE_DEF,
    parameter int unsigned POS_W         = POS_W_DEF,
    parameter int unsigned SBH_THRESHOLD = SBH_THRESHOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    output logic               in_ready,
    input  logic [COEFF_W-2:0] level_in,
    input  logic               sign_in,
    input  logic [POS_W-1:0]   scan_pos_in,
    input  logic               load_done,
    output logic [COEFF_W-1:0] coef_out,
    output logic [POS_W-1:0]   scan_pos_out,
    output logic               sign_hidden_out,
    output logic               last_out,
    output logic               valid_out,
    input  logic               ready_in
);

    localparam logic [POS_W-1:0] LastIdx = POS_W'(CG_SIZE - 1);
    localparam logic [POS_W-1:0] Thresh  = POS_W'(SBH_THRESHOLD);

    sbh_state_e         state_q;
    sbh_entry_t         mem_q [CG_SIZE];
    logic [POS_W-1:0]   emit_idx_q;
    logic               sign_hidden_q;
    logic               valid_q;
    logic               last_q;
    logic [COEFF_W-1:0] coef_q;
    logic [POS_W-1:0]   pos_q;

    logic               scan_start;
    logic [POS_W-1:0]   scan_idx;
    logic               scan_done;
    logic [POS_W-1:0]   first_nz;
    logic [POS_W-1:0]   last_nz;
    logic               has_nz;
    logic               parity;
    logic               hidden_now;
    logic               emit_fire;
    logic               emit_final;

    logic [POS_W-1:0]   beat_idx;
    logic               beat_hidden;
    logic               beat_sign;
    sbh_entry_t         beat_entry;
    logic [COEFF_W-1:0] beat_mag;
    logic [COEFF_W-1:0] beat_coef;

    assign in_ready        = (state_q == StLoad);
    assign coef_out        = coef_q;
    assign scan_pos_out    = pos_q;
    assign sign_hidden_out = sign_hidden_q;
    assign last_out        = last_q;
    assign valid_out       = valid_q;

    assign scan_start = (state_q == StLoad) && load_done;
    assign hidden_now = has_nz && ((last_nz - first_nz) >= Thresh);
    assign emit_fire  = (state_q == StEmit) && valid_q && ready_in;
    assign emit_final = emit_fire && (emit_idx_q == LastIdx);

    sbh_nz_parity_scan #(
        .LEVEL_W (LEVEL_W),
        .CG_SIZE (CG_SIZE),
        .POS_W   (POS_W)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (scan_start),
        .level    (mem_q[scan_idx].level),
        .idx      (scan_idx),
        .done     (scan_done),
        .first_nz (first_nz),
        .last_nz  (last_nz),
        .has_nz   (has_nz),
        .parity   (parity)
    );

    // Coefficient storage: written only while loading, wiped after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CG_SIZE); i++) begin
                mem_q[i] <= '0;
            end
        end else if ((state_q == StLoad) && valid_in) begin
            mem_q[scan_pos_in] <= '{level: level_in, sign: sign_in};
        end else if (emit_final) begin
            for (int i = 0; i < int'(CG_SIZE); i++) begin
                mem_q[i] <= '0;
            end
        end
    end

    // Next beat to present: index 0 when leaving DECIDE, otherwise the following index.
    always_comb begin
        beat_idx    = (state_q == StDecide) ? '0 : (emit_idx_q + 1'b1);
        beat_hidden = (state_q == StDecide) ? hidden_now : sign_hidden_q;
        beat_entry  = mem_q[beat_idx];
        // The hidden sign replaces the parsed sign at the first non-zero position; odd = negative.
        beat_sign   = (beat_hidden && (beat_idx == first_nz)) ? parity : beat_entry.sign;
        beat_mag    = {1'b0, beat_entry.level};
        beat_coef   = '0;
        if (beat_entry.level != '0) begin
            beat_coef = beat_sign ? (-beat_mag) : beat_mag;
        end
    end

    // Control FSM with registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StLoad;
            emit_idx_q    <= '0;
            sign_hidden_q <= 1'b0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            coef_q        <= '0;
            pos_q         <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (load_done) begin
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (scan_done) begin
                        state_q <= StDecide;
                    end
                end
                StDecide: begin
                    state_q       <= StEmit;
                    sign_hidden_q <= hidden_now;
                    emit_idx_q    <= beat_idx;
                    valid_q       <= 1'b1;
                    coef_q        <= beat_coef;
                    pos_q         <= beat_idx;
                    last_q        <= (beat_idx == LastIdx);
                end
                StEmit: begin
                    if (emit_final) begin
                        state_q       <= StLoad;
                        emit_idx_q    <= '0;
                        sign_hidden_q <= 1'b0;
                        valid_q       <= 1'b0;
                        last_q        <= 1'b0;
                        coef_q        <= '0;
                        pos_q         <= '0;
                    end else if (emit_fire) begin
                        emit_idx_q <= beat_idx;
                        coef_q     <= beat_coef;
                        pos_q      <= beat_idx;
                        last_q     <= (beat_idx == LastIdx);
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

endmodule
